fma16_mul_seq: RTL and testbench
================================

FMA16_MUL_SEQ -- requirements
Module: fma16_mul_seq

Interface
REQ-001 SHALL have parameter BIAS, default 15, meaning the half-precision exponent bias.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  classified operand set present.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have ports xs, ys  input  1 each  operand signs.
REQ-007 SHALL have ports xe, ye  input  5 each  biased exponents.
REQ-008 SHALL have ports xm, ym  input  10 each  stored fractions.
REQ-009 SHALL have ports x_zero, y_zero, x_inf, y_inf, x_nan, y_nan  input  1 each  operand class flags.
REQ-010 SHALL have port out_valid  output  1  product available.
REQ-011 SHALL have port out_ready  input  1  consumer accepts product.
REQ-012 SHALL have port ps  output  1  product sign.
REQ-013 SHALL have port pe  output  7  two's-complement unbiased-sum exponent.
REQ-014 SHALL have port pm  output  22  full significand product.
REQ-015 SHALL have ports p_zero, p_inf, p_nan, p_invalid  output  1 each  product class flags.

Function
REQ-016 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-017 SHALL drive in_ready = (state==IDLE) & ~reset.
REQ-018 SHALL capture all inputs on an edge where in_valid & in_ready.
REQ-019 SHALL form each significand as {e!=0, m}, 11 bits.
REQ-020 SHALL use effective exponent 1 when e==0 (subnormal).
REQ-021 SHALL compute pe = eff(xe) + eff(ye) - BIAS; the result range is -13..45 and does not overflow 7 bits.
REQ-022 SHALL compute ps = xs ^ ys in every case.
REQ-023 SHALL compute pm by radix-2 shift-add, one multiplier bit per cycle, LSB first, 11 BUSY cycles, and pm SHALL be exact.
REQ-024 SHALL, on a non-special accept, transition IDLE->BUSY, then BUSY->DONE after the 11th iteration, raising out_valid 12 cycles after the accept edge.
REQ-025 SHALL compute p_nan = x_nan | y_nan | (x_zero & y_inf) | (x_inf & y_zero).
REQ-026 SHALL compute p_invalid = (x_zero & y_inf) | (x_inf & y_zero) | (x_nan & ~xm[9]) | (y_nan & ~ym[9]).
REQ-027 SHALL compute p_inf = (x_inf | y_inf) & ~p_nan, and p_zero = (x_zero | y_zero) & ~p_nan & ~p_inf.
REQ-028 SHALL, on a special accept (any class flag set), go IDLE->DONE directly with pm=0 and pe=0, so out_valid rises 1 cycle after accept.
REQ-029 SHALL hold out_valid and all product outputs stable while out_valid & ~out_ready.
REQ-030 SHALL go DONE->IDLE on out_valid & out_ready; in_ready SHALL rise the following cycle, so no same-cycle re-accept occurs.
REQ-031 SHALL ignore in_valid outside IDLE.
REQ-032 SHALL keep product outputs unchanged in IDLE/BUSY; they are meaningful only when out_valid=1.

Reset
REQ-033 SHALL on reset set state=IDLE, out_valid=0, and ps, pe, pm, p_zero, p_inf, p_nan, p_invalid and internal accumulator/counter to 0.
REQ-034 SHALL abort any in-flight operation on reset (BUSY or DONE), with no product delivered.
REQ-035 SHALL hold in_ready at 0 during any cycle with reset=1 and at 1 on the first cycle after reset deasserts.

Structure
REQ-036 SHALL take the state enum, BIAS, and widths (significand 11, product 22, exponent 7) from shared package fma16_pkg.
REQ-037 SHALL use a single sub-module fma16_mul_datapath (accumulator, multiplicand shift register, 4-bit iteration counter); the FSM stays in the top level.

Verification
REQ-038 SHALL verify 1.0*1.0 (xe=ye=15, xm=ym=0): pm=0x100000, pe=15, ps=0, flags 0, out_valid exactly 12 cycles after accept.
REQ-039 SHALL verify -1.5*2.0 (xs=1, xe=15, xm=0x200; ye=16, ym=0): pm=0x180000, pe=16, ps=1.
REQ-040 SHALL verify subnormal 0x0001 * 1.0 (xe=0, xm=1): pm=0x000400, pe=1.
REQ-041 SHALL verify zero*inf (x_zero=1, y_inf=1): p_nan=1, p_invalid=1, pm=0, out_valid 1 cycle after accept; also x=sNaN (x_nan=1, xm=0x100): p_nan=1, p_invalid=1.
REQ-042 SHALL verify backpressure: out_ready=0 for 5 cycles in DONE gives outputs stable and in_ready=0; after the handshake, in_ready=1 on the next cycle and a new accept succeeds.
REQ-043 SHALL verify reset asserted on the 5th BUSY cycle: out_valid never rises, all outputs are 0, and in_ready=1 on the first cycle after reset deasserts.

Source files
------------

// File: rtl/fma16_pkg.sv
// Shared constants, widths and FSM state type for the fma16 multiplier slice.
package fma16_pkg;

  localparam int HP_BIAS = 15;
  localparam int BEXP_W  = 5;
  localparam int FRAC_W  = 10;
  localparam int SIG_W   = 11;
  localparam int PROD_W  = 22;
  localparam int EXP_W   = 7;
  localparam int CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Subnormals share the exponent of the smallest normal.
  function automatic logic [BEXP_W-1:0] eff_exp(input logic [BEXP_W-1:0] e);
    return (e == '0) ? BEXP_W'(1) : e;
  endfunction

endpackage

// File: rtl/fma16_mul_datapath.sv
// Radix-2 shift-add significand multiplier: one multiplier bit per step, LSB first.
module fma16_mul_datapath
  import fma16_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_step,
  input  logic [SIG_W-1:0]  i_mcand,
  input  logic [SIG_W-1:0]  i_mplier,
  output logic [PROD_W-1:0] o_acc_next,
  output logic              o_last
);

  logic [PROD_W-1:0] r_acc;
  logic [PROD_W-1:0] r_mcand;
  logic [SIG_W-1:0]  r_mplier;
  logic [CNT_W-1:0]  r_cnt;

  // 11x11 fits in 22 bits, so the running sum never overflows.
  assign o_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign o_last     = (r_cnt == CNT_W'(SIG_W - 1));

  // Load operands on accept, then add-and-shift once per step.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (i_load) begin
      r_acc    <= '0;
      r_mcand  <= {{(PROD_W-SIG_W){1'b0}}, i_mcand};
      r_mplier <= i_mplier;
      r_cnt    <= '0;
    end else if (i_step) begin
      r_acc    <= o_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fma16_mul_seq.sv
// Sequential half-precision significand multiplier with class-flag handling.
//  state | meaning
//  IDLE  | waiting for an operand set, in_ready high
//  BUSY  | shift-add iterations running in the datapath
//  DONE  | product held on outputs until out_ready
module fma16_mul_seq
  import fma16_pkg::*;
#(
  parameter int BIAS = HP_BIAS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              xs,
  input  logic              ys,
  input  logic [BEXP_W-1:0] xe,
  input  logic [BEXP_W-1:0] ye,
  input  logic [FRAC_W-1:0] xm,
  input  logic [FRAC_W-1:0] ym,
  input  logic              x_zero,
  input  logic              y_zero,
  input  logic              x_inf,
  input  logic              y_inf,
  input  logic              x_nan,
  input  logic              y_nan,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              ps,
  output logic [EXP_W-1:0]  pe,
  output logic [PROD_W-1:0] pm,
  output logic              p_zero,
  output logic              p_inf,
  output logic              p_nan,
  output logic              p_invalid
);

  state_t            r_state;
  logic              r_out_valid;
  logic              r_ps;
  logic [EXP_W-1:0]  r_pe;
  logic [PROD_W-1:0] r_pm;
  logic              r_p_zero;
  logic              r_p_inf;
  logic              r_p_nan;
  logic              r_p_invalid;
  // Sign and exponent computed at accept, published when the product is ready.
  logic              r_ps_q;
  logic [EXP_W-1:0]  r_pe_q;

  logic              w_accept;
  logic              w_special;
  logic              w_load;
  logic              w_step;
  logic              w_nan;
  logic              w_invalid;
  logic              w_inf;
  logic              w_zero;
  logic [EXP_W-1:0]  w_pe;
  logic [SIG_W-1:0]  w_xsig;
  logic [SIG_W-1:0]  w_ysig;
  logic [PROD_W-1:0] w_acc_next;
  logic              w_last;

  assign in_ready  = (r_state == IDLE) & ~reset;
  assign w_accept  = in_valid & in_ready;
  assign w_special = x_zero | y_zero | x_inf | y_inf | x_nan | y_nan;
  assign w_load    = w_accept & ~w_special;
  assign w_step    = (r_state == BUSY);

  assign w_nan     = x_nan | y_nan | (x_zero & y_inf) | (x_inf & y_zero);
  assign w_invalid = (x_zero & y_inf) | (x_inf & y_zero)
                   | (x_nan & ~xm[FRAC_W-1]) | (y_nan & ~ym[FRAC_W-1]);
  assign w_inf     = (x_inf | y_inf) & ~w_nan;
  assign w_zero    = (x_zero | y_zero) & ~w_nan & ~w_inf;

  // Range is -13..45, which always fits the 7-bit two's-complement result.
  assign w_pe   = {2'b00, eff_exp(xe)} + {2'b00, eff_exp(ye)} - EXP_W'(BIAS);
  assign w_xsig = {(xe != '0), xm};
  assign w_ysig = {(ye != '0), ym};

  fma16_mul_datapath u_dp (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_step     (w_step),
    .i_mcand    (w_xsig),
    .i_mplier   (w_ysig),
    .o_acc_next (w_acc_next),
    .o_last     (w_last)
  );

  // Control FSM with registered product outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_ps        <= 1'b0;
      r_pe        <= '0;
      r_pm        <= '0;
      r_p_zero    <= 1'b0;
      r_p_inf     <= 1'b0;
      r_p_nan     <= 1'b0;
      r_p_invalid <= 1'b0;
      r_ps_q      <= 1'b0;
      r_pe_q      <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_special) begin
              r_ps        <= xs ^ ys;
              r_pe        <= '0;
              r_pm        <= '0;
              r_p_zero    <= w_zero;
              r_p_inf     <= w_inf;
              r_p_nan     <= w_nan;
              r_p_invalid <= w_invalid;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_ps_q  <= xs ^ ys;
              r_pe_q  <= w_pe;
              r_state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (w_last) begin
            r_ps        <= r_ps_q;
            r_pe        <= r_pe_q;
            r_pm        <= w_acc_next;
            r_p_zero    <= 1'b0;
            r_p_inf     <= 1'b0;
            r_p_nan     <= 1'b0;
            r_p_invalid <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign ps        = r_ps;
  assign pe        = r_pe;
  assign pm        = r_pm;
  assign p_zero    = r_p_zero;
  assign p_inf     = r_p_inf;
  assign p_nan     = r_p_nan;
  assign p_invalid = r_p_invalid;

endmodule

// File: tb/tb_fma16_mul_seq.sv
// Self-checking bench for fma16_mul_seq: directed table, corner sequences, random ops.
module tb_fma16_mul_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        xs, ys;
  logic [4:0]  xe, ye;
  logic [9:0]  xm, ym;
  logic [5:0]  cls;  // {x_zero, y_zero, x_inf, y_inf, x_nan, y_nan}
  logic        out_valid;
  logic        out_ready;
  logic        ps;
  logic [6:0]  pe;
  logic [21:0] pm;
  logic        p_zero, p_inf, p_nan, p_invalid;

  always #5 clk = ~clk;

  fma16_mul_seq #(.BIAS(15)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .xs        (xs),
    .ys        (ys),
    .xe        (xe),
    .ye        (ye),
    .xm        (xm),
    .ym        (ym),
    .x_zero    (cls[5]),
    .y_zero    (cls[4]),
    .x_inf     (cls[3]),
    .y_inf     (cls[2]),
    .x_nan     (cls[1]),
    .y_nan     (cls[0]),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ps        (ps),
    .pe        (pe),
    .pm        (pm),
    .p_zero    (p_zero),
    .p_inf     (p_inf),
    .p_nan     (p_nan),
    .p_invalid (p_invalid)
  );

  typedef struct {
    logic        xs;
    logic [4:0]  xe;
    logic [9:0]  xm;
    logic        ys;
    logic [4:0]  ye;
    logic [9:0]  ym;
    logic [5:0]  cls;
    logic        e_ps;
    logic [6:0]  e_pe;
    logic [21:0] e_pm;
    logic [3:0]  e_fl;   // {zero, inf, nan, invalid}
    int          e_lat;  // accept edge counts as cycle 1
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic xs_i, input logic [4:0] xe_i, input logic [9:0] xm_i,
                              input logic ys_i, input logic [4:0] ye_i, input logic [9:0] ym_i,
                              input logic [5:0] cls_i, input logic e_ps_i, input logic [6:0] e_pe_i,
                              input logic [21:0] e_pm_i, input logic [3:0] e_fl_i, input int e_lat_i);
    vec_t v;
    v.xs = xs_i; v.xe = xe_i; v.xm = xm_i;
    v.ys = ys_i; v.ye = ye_i; v.ym = ym_i;
    v.cls = cls_i;
    v.e_ps = e_ps_i; v.e_pe = e_pe_i; v.e_pm = e_pm_i; v.e_fl = e_fl_i; v.e_lat = e_lat_i;
    return v;
  endfunction

  // Reference: IEEE-style significand product with plain integer arithmetic.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int sx, sy, ex, ey;
    logic xz, yz, xi, yi, xn, yn, nan, inv, inf, zer;
    r = v;
    {xz, yz, xi, yi, xn, yn} = v.cls;
    nan = xn | yn | (xz & yi) | (xi & yz);
    inv = (xz & yi) | (xi & yz) | (xn & ~v.xm[9]) | (yn & ~v.ym[9]);
    inf = (xi | yi) & ~nan;
    zer = (xz | yz) & ~nan & ~inf;
    r.e_ps = v.xs ^ v.ys;
    if (v.cls != 6'd0) begin
      r.e_pm = 22'd0; r.e_pe = 7'd0; r.e_fl = {zer, inf, nan, inv}; r.e_lat = 1;
    end else begin
      sx = ((v.xe != 0) ? 1024 : 0) + int'(v.xm);
      sy = ((v.ye != 0) ? 1024 : 0) + int'(v.ym);
      ex = (v.xe == 0) ? 1 : int'(v.xe);
      ey = (v.ye == 0) ? 1 : int'(v.ye);
      r.e_pm = 22'(sx * sy);
      r.e_pe = 7'(ex + ey - 15);
      r.e_fl = 4'd0;
      r.e_lat = 12;
    end
    return r;
  endfunction

  task automatic run_op(input vec_t v, input int hold, input string tag);
    int lat;
    int t;
    @(negedge clk);
    xs = v.xs; xe = v.xe; xm = v.xm; ys = v.ys; ye = v.ye; ym = v.ym; cls = v.cls;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    // Inputs (valid still high) must be ignored once the operand set is captured.
    if (!out_valid) begin
      xe = 5'($urandom); xm = 10'($urandom); ye = 5'($urandom); ym = 10'($urandom);
      xs = 1'($urandom); ys = 1'($urandom); cls = 6'($urandom);
    end
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    chk({tag, " latency"}, 32'(lat), 32'(v.e_lat));
    chk({tag, " pm"}, 32'(pm), 32'(v.e_pm));
    chk({tag, " pe"}, 32'(pe), 32'(v.e_pe));
    chk({tag, " ps"}, 32'(ps), 32'(v.e_ps));
    chk({tag, " flags"}, 32'({p_zero, p_inf, p_nan, p_invalid}), 32'(v.e_fl));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, " hold valid/ready"}, 32'({out_valid, in_ready}), 32'b10);
      chk({tag, " hold outputs"}, {pm, pe, ps, p_zero, p_inf},
          {v.e_pm, v.e_pe, v.e_ps, v.e_fl[3:2]});
      chk({tag, " hold flags"}, 32'({p_nan, p_invalid}), 32'(v.e_fl[1:0]));
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " after handshake valid/ready"}, 32'({out_valid, in_ready}), 32'b01);
  endtask

  vec_t tbl[10];
  vec_t rv;
  int   seen;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    xs = 0; ys = 0; xe = 0; ye = 0; xm = 0; ym = 0; cls = 0;

    tbl[0] = mk(0, 5'd15, 10'h000, 0, 5'd15, 10'h000, 6'b000000, 0, 7'd15,   22'h100000, 4'b0000, 12);
    tbl[1] = mk(1, 5'd15, 10'h200, 0, 5'd16, 10'h000, 6'b000000, 1, 7'd16,   22'h180000, 4'b0000, 12);
    tbl[2] = mk(0, 5'd0,  10'h001, 0, 5'd15, 10'h000, 6'b000000, 0, 7'd1,    22'h000400, 4'b0000, 12);
    tbl[3] = mk(0, 5'd0,  10'h000, 1, 5'd31, 10'h000, 6'b100100, 1, 7'd0,    22'h000000, 4'b0011, 1);
    tbl[4] = mk(0, 5'd31, 10'h100, 0, 5'd15, 10'h000, 6'b000010, 0, 7'd0,    22'h000000, 4'b0011, 1);
    tbl[5] = mk(1, 5'd31, 10'h200, 1, 5'd15, 10'h000, 6'b000010, 0, 7'd0,    22'h000000, 4'b0010, 1);
    tbl[6] = mk(1, 5'd31, 10'h000, 0, 5'd16, 10'h000, 6'b001000, 1, 7'd0,    22'h000000, 4'b0100, 1);
    tbl[7] = mk(0, 5'd16, 10'h200, 1, 5'd0,  10'h000, 6'b010000, 1, 7'd0,    22'h000000, 4'b1000, 1);
    tbl[8] = mk(0, 5'd30, 10'h3FF, 1, 5'd30, 10'h3FF, 6'b000000, 1, 7'h2D,   22'h3FF001, 4'b0000, 12);
    tbl[9] = mk(0, 5'd0,  10'h3FF, 0, 5'd0,  10'h001, 6'b000000, 0, 7'h73,   22'h0003FF, 4'b0000, 12);

    repeat (3) @(negedge clk);
    chk("reset in_ready", 32'(in_ready), 32'd0);
    chk("reset outputs", {pm, pe, ps, out_valid, p_zero, p_inf},
        32'd0);
    chk("reset flags", 32'({p_nan, p_invalid}), 32'd0);
    reset = 1'b0;
    #1;
    chk("in_ready after reset", 32'(in_ready), 32'd1);

    for (int i = 0; i < 10; i++)
      run_op(tbl[i], (i == 0) ? 5 : (i % 3), $sformatf("vec%0d", i));

    // Abort on reset during the 5th BUSY cycle.
    @(negedge clk);
    xs = 1; xe = 5'd20; xm = 10'h155; ys = 0; ye = 5'd18; ym = 10'h2AA; cls = 6'd0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort in_ready during reset", 32'(in_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort outputs", {pm, pe, ps, out_valid, p_zero, p_inf}, 32'd0);
    chk("abort flags", 32'({p_nan, p_invalid}), 32'd0);
    chk("abort in_ready after reset", 32'(in_ready), 32'd1);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("abort no product", 32'(seen), 32'd0);

    // Random operands against the reference model.
    for (int i = 0; i < 200; i++) begin
      rv.xs = 1'($urandom); rv.ys = 1'($urandom);
      rv.xe = 5'($urandom_range(0, 30)); rv.ye = 5'($urandom_range(0, 30));
      rv.xm = 10'($urandom); rv.ym = 10'($urandom);
      rv.cls = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
      rv = model(rv);
      run_op(rv, $urandom_range(0, 3), $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
